// File: rtl/resp_arbiter_if.sv
// ----------------------------------------------------------------------------
// resp_arbiter_if
//  Signal bundle between the response arbiter and its neighbours:
//  cmd_cfg (ack bytes), the telemetry source and UART_comm (response channel).
//
//  ack_resp  [7:0]  ack byte, valid when ack_send=1
//  ack_send         1-cycle request to transmit ack_resp
//  tlm_byte  [7:0]  telemetry byte, stable while tlm_vld=1
//  tlm_vld          telemetry byte available (level)
//  tlm_rdy          1-cycle pulse: telemetry byte accepted
//  resp      [7:0]  byte to UART_comm
//  send_resp        1-cycle pulse starting transmission of resp
//  resp_sent        pulse from UART_comm: transmission complete
//  busy             arbiter has a byte in flight
//  ack_ovf          sticky: an unsent ack was overwritten
//  tmo_err          sticky: resp_sent watchdog expired
//  clr_err          clears ack_ovf and tmo_err
//
//  Modports: slave = arbiter side, master = surrounding logic / testbench.
// ----------------------------------------------------------------------------
interface resp_arbiter_if;
    logic [7:0] ack_resp;
    logic       ack_send;
    logic [7:0] tlm_byte;
    logic       tlm_vld;
    logic       tlm_rdy;
    logic [7:0] resp;
    logic       send_resp;
    logic       resp_sent;
    logic       busy;
    logic       ack_ovf;
    logic       tmo_err;
    logic       clr_err;

    modport slave (
        input  ack_resp, ack_send, tlm_byte, tlm_vld, resp_sent, clr_err,
        output tlm_rdy, resp, send_resp, busy, ack_ovf, tmo_err
    );

    modport master (
        output ack_resp, ack_send, tlm_byte, tlm_vld, resp_sent, clr_err,
        input  tlm_rdy, resp, send_resp, busy, ack_ovf, tmo_err
    );
endinterface

// File: rtl/resp_arbiter.sv
// ----------------------------------------------------------------------------
// resp_arbiter
//  Shares UART_comm's single response channel between cmd_cfg ack bytes and a
//  telemetry byte stream, one byte in flight at a time. Acks have priority;
//  after STREAK consecutive ack grants with telemetry waiting, telemetry is
//  forced through so it cannot be starved. A watchdog abandons a byte if
//  resp_sent never arrives.
//
//  Parameters:
//   STREAK    max consecutive ack grants while tlm_vld is high
//   TMO_W     width of the resp_sent watchdog counter
//   TMO_CLKS  WAIT cycles without resp_sent before the byte is abandoned
//
//  Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    resp_arbiter_if.slave (ack, telemetry, UART and status signals)
// ----------------------------------------------------------------------------
module resp_arbiter #(
    parameter int unsigned STREAK   = 4,
    parameter int unsigned TMO_W    = 20,
    parameter int unsigned TMO_CLKS = 20'hFFFFF
) (
    input  logic          clk,
    input  logic          rst_n,
    resp_arbiter_if.slave bus
);

    localparam int unsigned       SW         = (STREAK < 1) ? 1 : $clog2(STREAK + 1);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(STREAK);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TMO_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [7:0]       r_ack_buf;
    logic             r_ack_pend;
    logic [7:0]       r_resp;
    logic [SW-1:0]    r_streak;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_ack_ovf;
    logic             r_tmo_err;

    logic             w_grant_ack;
    logic             w_grant_tlm;
    logic             w_tmo_hit;
    logic             w_send;
    logic             w_busy;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and grant decision
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_ack = 1'b0;
        w_grant_tlm = 1'b0;
        w_tmo_hit   = 1'b0;
        w_send      = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                // Ack wins unless telemetry is waiting and the ack streak is used up.
                if (r_ack_pend && !(bus.tlm_vld && (r_streak == STREAK_MAX))) begin
                    w_grant_ack = 1'b1;
                    w_state_nxt = LOAD;
                end else if (bus.tlm_vld) begin
                    w_grant_tlm = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_send      = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.resp_sent) begin
                    w_state_nxt = IDLE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Ack buffer, response register, streak, watchdog and sticky flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_buf  <= '0;
            r_ack_pend <= 1'b0;
            r_resp     <= '0;
            r_streak   <= '0;
            r_tmo_cnt  <= '0;
            r_ack_ovf  <= 1'b0;
            r_tmo_err  <= 1'b0;
        end else begin
            if (bus.ack_send) begin
                r_ack_buf <= bus.ack_resp;
            end

            // A new ack arriving in the grant cycle refills the buffer, so pend stays set.
            if (bus.ack_send) begin
                r_ack_pend <= 1'b1;
            end else if (w_grant_ack) begin
                r_ack_pend <= 1'b0;
            end

            if (bus.ack_send && r_ack_pend && !w_grant_ack) begin
                r_ack_ovf <= 1'b1;
            end else if (bus.clr_err) begin
                r_ack_ovf <= 1'b0;
            end

            if (w_tmo_hit) begin
                r_tmo_err <= 1'b1;
            end else if (bus.clr_err) begin
                r_tmo_err <= 1'b0;
            end

            // resp only changes on a grant, so it is stable from LOAD through WAIT.
            if (w_grant_ack) begin
                r_resp <= r_ack_buf;
            end else if (w_grant_tlm) begin
                r_resp <= bus.tlm_byte;
            end

            // Streak counts consecutive ack grants while telemetry is waiting.
            if (r_state == IDLE) begin
                if (!bus.tlm_vld) begin
                    r_streak <= '0;
                end else if (w_grant_ack) begin
                    if (r_streak != STREAK_MAX) begin
                        r_streak <= r_streak + SW'(1);
                    end
                end else if (w_grant_tlm) begin
                    r_streak <= '0;
                end
            end

            if (r_state == LOAD) begin
                r_tmo_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
        end
    end

    assign bus.send_resp = w_send;
    assign bus.busy      = w_busy;
    // Held low in reset so the telemetry source never advances without a byte being sent.
    assign bus.tlm_rdy   = w_grant_tlm & rst_n;
    assign bus.resp      = r_resp;
    assign bus.ack_ovf   = r_ack_ovf;
    assign bus.tmo_err   = r_tmo_err;

endmodule

// File: tb/tb_resp_arbiter.sv
// ----------------------------------------------------------------------------
// tb_resp_arbiter
//  Directed scenarios for resp_arbiter followed by a randomized phase checked
//  against a transaction-level reference model of the arbitration rules.
// ----------------------------------------------------------------------------
module tb_resp_arbiter;

    localparam int unsigned STREAK   = 4;
    localparam int unsigned TMO_CLKS = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    resp_arbiter_if bus ();

    resp_arbiter #(
        .STREAK   (STREAK),
        .TMO_W    (20),
        .TMO_CLKS (TMO_CLKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    int unsigned n_rdy = 0;

    always @(negedge clk) begin
        if (bus.tlm_rdy === 1'b1) n_rdy++;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.ack_send  = 1'b0;
        bus.resp_sent = 1'b0;
        bus.clr_err   = 1'b0;
    endtask

    task automatic ack_pulse(input logic [7:0] b);
        bus.ack_resp = b;
        bus.ack_send = 1'b1;
    endtask

    // Advance until send_resp is seen (bounded); leaves the bench in the LOAD cycle.
    task automatic expect_send(input string tag, input logic [7:0] b,
                               input int unsigned max_cyc, output int unsigned lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus.send_resp !== 1'b1 && lat < max_cyc);
        check({tag, "_seen"}, bus.send_resp, 1);
        check({tag, "_resp"}, bus.resp, b);
    endtask

    // From LOAD: one WAIT cycle with resp_sent (optionally a new ack), then idle.
    task automatic complete(input bit do_ack, input logic [7:0] ab);
        tick();
        check("wait_busy", bus.busy, 1);
        if (do_ack) ack_pulse(ab);
        bus.resp_sent = 1'b1;
        tick();
        check("idle_after_sent", bus.busy, 0);
    endtask

    initial begin
        int unsigned lat, rdy0, s;
        logic [7:0]  m_buf, m_byte, exp_b;
        int unsigned m_streak, m_phase, m_wait;
        bit          m_pend, m_ovf, m_drop, g_ack, g_tlm, clr, ovf_set;

        bus.ack_resp  = '0;
        bus.ack_send  = 1'b0;
        bus.tlm_byte  = '0;
        bus.tlm_vld   = 1'b0;
        bus.resp_sent = 1'b0;
        bus.clr_err   = 1'b0;

        // Reset state
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_send", bus.send_resp, 0);
        check("rst_rdy",  bus.tlm_rdy, 0);
        check("rst_resp", bus.resp, 0);
        check("rst_ovf",  bus.ack_ovf, 0);
        check("rst_tmo",  bus.tmo_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: single ack, two-cycle latency
        ack_pulse(8'hA5);
        expect_send("t1", 8'hA5, 10, lat);
        check("t1_lat", lat, 2);
        complete(1'b0, 8'h00);

        // 2: ack pending beats newly arrived telemetry
        rdy0 = n_rdy;
        ack_pulse(8'h5A);
        expect_send("t2a", 8'h5A, 10, lat);
        tick();
        bus.tlm_byte = 8'h3C;
        bus.tlm_vld  = 1'b1;
        ack_pulse(8'hA5);
        tick();
        bus.resp_sent = 1'b1;
        tick();
        #1;
        check("t2_rdy_low", bus.tlm_rdy, 0);
        expect_send("t2b", 8'hA5, 10, lat);
        complete(1'b0, 8'h00);
        #1;
        check("t2_rdy_high", bus.tlm_rdy, 1);
        expect_send("t2c", 8'h3C, 10, lat);
        bus.tlm_vld = 1'b0;
        complete(1'b0, 8'h00);
        check("t2_rdy_once", n_rdy - rdy0, 1);

        // 3: streak limit with telemetry held
        rdy0 = n_rdy;
        ack_pulse(8'h80);
        tick();
        bus.tlm_byte = 8'hC0;
        bus.tlm_vld  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_b = (i < 4) ? 8'(8'h80 + i) : ((i == 4) ? 8'hC0 : 8'h84);
            expect_send($sformatf("t3_%0d", i), exp_b, 10, lat);
            if (i == 4) bus.tlm_byte = 8'hC1;
            if (i == 5) bus.tlm_vld = 1'b0;
            complete(i < 4, 8'(8'h81 + i));
        end
        check("t3_rdy_once", n_rdy - rdy0, 1);

        // 4: overwrite of an unsent ack, then clear
        ack_pulse(8'h33);
        expect_send("t4a", 8'h33, 10, lat);
        tick();
        ack_pulse(8'h11);
        tick();
        ack_pulse(8'h22);
        tick();
        check("t4_ovf_set", bus.ack_ovf, 1);
        bus.resp_sent = 1'b1;
        tick();
        expect_send("t4b", 8'h22, 10, lat);
        complete(1'b0, 8'h00);
        s = 0;
        repeat (5) begin
            tick();
            if (bus.send_resp === 1'b1) s++;
        end
        check("t4_no_extra", s, 0);
        check("t4_ovf_held", bus.ack_ovf, 1);
        bus.clr_err = 1'b1;
        tick();
        check("t4_ovf_clr", bus.ack_ovf, 0);

        // 5: watchdog
        ack_pulse(8'h44);
        expect_send("t5a", 8'h44, 10, lat);
        for (int k = 0; k < int'(TMO_CLKS); k++) begin
            tick();
            check($sformatf("t5_wait_tmo_%0d", k), bus.tmo_err, 0);
            check($sformatf("t5_wait_busy_%0d", k), bus.busy, 1);
        end
        tick();
        check("t5_tmo_set", bus.tmo_err, 1);
        check("t5_idle", bus.busy, 0);
        ack_pulse(8'h55);
        expect_send("t5b", 8'h55, 10, lat);
        check("t5b_lat", lat, 2);
        complete(1'b0, 8'h00);
        bus.clr_err = 1'b1;
        tick();
        check("t5_tmo_clr", bus.tmo_err, 0);

        // 6: async reset mid-WAIT with an ack pending
        ack_pulse(8'h66);
        expect_send("t6a", 8'h66, 10, lat);
        tick();
        ack_pulse(8'h77);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", bus.busy, 0);
        check("t6_send", bus.send_resp, 0);
        check("t6_rdy",  bus.tlm_rdy, 0);
        check("t6_resp", bus.resp, 0);
        check("t6_ovf",  bus.ack_ovf, 0);
        check("t6_tmo",  bus.tmo_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s = 0;
        repeat (8) begin
            tick();
            if (bus.send_resp === 1'b1) s++;
        end
        check("t6_no_send", s, 0);

        // Randomized phase against a transaction-level model
        m_buf = '0; m_byte = '0; m_streak = 0; m_phase = 0; m_wait = 0;
        m_pend = 1'b0; m_ovf = 1'b0; m_drop = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            check("rnd_busy", bus.busy, m_phase != 0);
            check("rnd_send", bus.send_resp, m_phase == 1);
            if (m_phase == 1) check("rnd_resp", bus.resp, m_byte);
            check("rnd_ovf", bus.ack_ovf, m_ovf);
            check("rnd_tmo", bus.tmo_err, 0);

            if (m_drop) begin
                bus.tlm_vld = 1'b0;
                m_drop = 1'b0;
            end
            clr = ($urandom_range(15) == 0);
            bus.clr_err = clr;
            if (m_phase == 0 && !m_pend && !bus.tlm_vld) begin
                case ($urandom_range(2))
                    0: ack_pulse(8'($urandom));
                    1: begin
                        bus.tlm_byte = 8'($urandom);
                        bus.tlm_vld  = 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                if ($urandom_range(4) == 0) ack_pulse(8'($urandom));
                if (m_phase == 2 && !bus.tlm_vld && $urandom_range(3) == 0) begin
                    bus.tlm_byte = 8'($urandom);
                    bus.tlm_vld  = 1'b1;
                end
            end
            case (m_phase)
                2:       bus.resp_sent = ($urandom_range(2) == 0) || (m_wait >= 8);
                1:       bus.resp_sent = ($urandom_range(3) == 0);
                default: bus.resp_sent = ($urandom_range(7) == 0);
            endcase

            g_ack = 1'b0;
            g_tlm = 1'b0;
            if (m_phase == 0) begin
                if (m_pend && !(bus.tlm_vld && m_streak == STREAK)) begin
                    g_ack  = 1'b1;
                    m_byte = m_buf;
                end else if (bus.tlm_vld) begin
                    g_tlm  = 1'b1;
                    m_byte = bus.tlm_byte;
                end
                if (!bus.tlm_vld)  m_streak = 0;
                else if (g_ack)    m_streak = (m_streak < STREAK) ? m_streak + 1 : STREAK;
                else if (g_tlm)    m_streak = 0;
            end
            #1;
            check("rnd_rdy", bus.tlm_rdy, g_tlm);

            ovf_set = bus.ack_send && m_pend && !g_ack;
            if (bus.ack_send) begin
                m_buf  = bus.ack_resp;
                m_pend = 1'b1;
            end else if (g_ack) begin
                m_pend = 1'b0;
            end
            if (ovf_set)  m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            case (m_phase)
                0: if (g_ack || g_tlm) m_phase = 1;
                1: begin
                    m_phase = 2;
                    m_wait  = 0;
                end
                default: begin
                    if (bus.resp_sent) m_phase = 0;
                    else               m_wait++;
                end
            endcase
            if (g_tlm) m_drop = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
